// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latq_wrseq_pkg.sv
// Shared types and constants for the latq bank write sequencer.
// The FSM walks IDLE -> SETUP -> OPEN -> HOLD so D settles around every E pulse.
package gf180mcu_fd_sc_mcu9t5v0__latq_wrseq_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    OPEN  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  localparam int DEF_SETUP_CYC = 1;
  localparam int DEF_OPEN_CYC  = 1;
  localparam int DEF_HOLD_CYC  = 1;

  // One counter serves all phases, so it is sized for the longest one.
  function automatic int phase_w(int s, int o, int h);
    int m;
    m = s;
    if (o > m) m = o;
    if (h > m) m = h;
    return $clog2(m) + 1;
  endfunction

endpackage

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latq_wrseq_if.sv
// Write request channel into the sequencer (valid/ready handshake).
interface gf180mcu_fd_sc_mcu9t5v0__latq_wrseq_if #(
  parameter int AW    = 3,
  parameter int WIDTH = 4
) ();
  logic             wr_valid;
  logic             wr_ready;
  logic [AW-1:0]    wr_addr;
  logic [WIDTH-1:0] wr_data;

  modport master (output wr_valid, output wr_addr, output wr_data, input wr_ready);
  modport slave  (input wr_valid, input wr_addr, input wr_data, output wr_ready);
endinterface

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latq_wrseq_dec.sv
// Registered one-hot latch-enable decoder with range check.
// E only opens while gated and the address is inside the bank; err flags a dropped write.
module gf180mcu_fd_sc_mcu9t5v0__latq_wrseq_dec #(
  parameter int DEPTH = 8,
  parameter int AW    = 3
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [AW-1:0]    addr,
  input  logic             gate,
  input  logic             fin,
  output logic [DEPTH-1:0] e,
  output logic             err
);

  localparam logic [AW:0] LIMIT = (AW+1)'(DEPTH);

  logic             in_range;
  logic [DEPTH-1:0] onehot;

  always_comb begin
    in_range = ({1'b0, addr} < LIMIT);
    onehot   = '0;
    for (int i = 0; i < DEPTH; i++) onehot[i] = (addr == AW'(i));
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      e   <= '0;
      err <= 1'b0;
    end else begin
      e   <= (gate && in_range) ? onehot : '0;
      err <= fin && !in_range;
    end
  end

endmodule

// File: rtl/gf180mcu_fd_sc_mcu9t5v0__latq_wrseq.sv
// Write sequencer for a transparent-high latq latch bank: setup D, pulse one E, hold D.
// Every output comes straight from a flop so E and D cannot glitch.
module gf180mcu_fd_sc_mcu9t5v0__latq_wrseq
  import gf180mcu_fd_sc_mcu9t5v0__latq_wrseq_pkg::*;
#(
  parameter int DEPTH     = 8,
  parameter int WIDTH     = 4,
  parameter int AW        = 3,
  parameter int SETUP_CYC = DEF_SETUP_CYC,
  parameter int OPEN_CYC  = DEF_OPEN_CYC,
  parameter int HOLD_CYC  = DEF_HOLD_CYC
) (
  input  logic                                 CLK,
  input  logic                                 RST,
  input  logic                                 VDD,
  input  logic                                 VSS,
  gf180mcu_fd_sc_mcu9t5v0__latq_wrseq_if.slave wr,
  output logic [WIDTH-1:0]                     D,
  output logic [DEPTH-1:0]                     E,
  output logic                                 done,
  output logic                                 err,
  output logic                                 busy
);

  localparam int CW = phase_w(SETUP_CYC, OPEN_CYC, HOLD_CYC);

  state_t        state, state_nxt;
  logic [CW-1:0] cnt, cnt_nxt;
  logic [AW-1:0] addr;
  logic          accept, fin, ready_q;
  logic          unused_pwr;

  assign unused_pwr  = VDD ^ VSS;
  assign wr.wr_ready = ready_q;

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state   <= IDLE;
      cnt     <= '0;
      D       <= '0;
      ready_q <= 1'b1;
      busy    <= 1'b0;
      done    <= 1'b0;
    end else begin
      state   <= state_nxt;
      cnt     <= cnt_nxt;
      ready_q <= (state_nxt == IDLE);
      busy    <= (state_nxt != IDLE);
      done    <= fin;
      if (accept) D <= wr.wr_data;
    end
  end

  // The address only matters while busy, so it carries no reset.
  always_ff @(posedge CLK) begin
    if (accept) addr <= wr.wr_addr;
  end

  always_comb begin
    state_nxt = state;
    cnt_nxt   = cnt;
    accept    = 1'b0;
    fin       = 1'b0;
    unique case (state)
      IDLE: begin
        if (wr.wr_valid) begin
          accept    = 1'b1;
          state_nxt = SETUP;
          cnt_nxt   = CW'(SETUP_CYC - 1);
        end
      end
      SETUP: begin
        if (cnt == '0) begin
          state_nxt = OPEN;
          cnt_nxt   = CW'(OPEN_CYC - 1);
        end else cnt_nxt = cnt - CW'(1);
      end
      OPEN: begin
        if (cnt == '0) begin
          state_nxt = HOLD;
          cnt_nxt   = CW'(HOLD_CYC - 1);
        end else cnt_nxt = cnt - CW'(1);
      end
      HOLD: begin
        if (cnt == '0) begin
          state_nxt = IDLE;
          cnt_nxt   = '0;
          fin       = 1'b1;
        end else cnt_nxt = cnt - CW'(1);
      end
      default: state_nxt = IDLE;
    endcase
  end

  gf180mcu_fd_sc_mcu9t5v0__latq_wrseq_dec #(
    .DEPTH(DEPTH),
    .AW   (AW)
  ) u_dec (
    .clk (CLK),
    .rst (RST),
    .addr(addr),
    .gate(state_nxt == OPEN),
    .fin (fin),
    .e   (E),
    .err (err)
  );

endmodule

// File: tb/tb_gf180mcu_fd_sc_mcu9t5v0__latq_wrseq.sv
// Directed bench for the latq write sequencer: default, DEPTH=6 and stretched-phase instances.
module tb_gf180mcu_fd_sc_mcu9t5v0__latq_wrseq;

  logic CLK = 1'b0;
  logic rst_a, rst_b, rst_c;
  logic vdd = 1'b1, vss = 1'b0;
  int   checks = 0, errors = 0;

  logic [3:0] d_a, d_b, d_c, prev_d_a, prev_d_b, prev_d_c;
  logic [7:0] e_a, e_c;
  logic [5:0] e_b;
  logic       done_a, done_b, done_c, err_a, err_b, err_c, busy_a, busy_b, busy_c;

  gf180mcu_fd_sc_mcu9t5v0__latq_wrseq_if #(.AW(3), .WIDTH(4)) bus_a (), bus_b (), bus_c ();

  always #5 CLK = ~CLK;

  gf180mcu_fd_sc_mcu9t5v0__latq_wrseq dut_a (
    .CLK(CLK), .RST(rst_a), .VDD(vdd), .VSS(vss), .wr(bus_a.slave),
    .D(d_a), .E(e_a), .done(done_a), .err(err_a), .busy(busy_a));

  gf180mcu_fd_sc_mcu9t5v0__latq_wrseq #(.DEPTH(6)) dut_b (
    .CLK(CLK), .RST(rst_b), .VDD(vdd), .VSS(vss), .wr(bus_b.slave),
    .D(d_b), .E(e_b), .done(done_b), .err(err_b), .busy(busy_b));

  gf180mcu_fd_sc_mcu9t5v0__latq_wrseq #(.SETUP_CYC(2), .OPEN_CYC(3), .HOLD_CYC(2)) dut_c (
    .CLK(CLK), .RST(rst_c), .VDD(vdd), .VSS(vss), .wr(bus_c.slave),
    .D(d_c), .E(e_c), .done(done_c), .err(err_c), .busy(busy_c));

  // Per-cycle invariants on all three instances.
  always @(negedge CLK) begin
    checks++;
    if ($countones(e_a) > 1 || bus_a.wr_ready !== !busy_a || (e_a != 0 && d_a !== prev_d_a)) begin
      errors++;
      $display("FAIL inv_a E=%h D=%h prevD=%h ready=%b busy=%b", e_a, d_a, prev_d_a, bus_a.wr_ready, busy_a);
    end
    checks++;
    if ($countones(e_b) > 1 || bus_b.wr_ready !== !busy_b || (e_b != 0 && d_b !== prev_d_b)) begin
      errors++;
      $display("FAIL inv_b E=%h D=%h prevD=%h ready=%b busy=%b", e_b, d_b, prev_d_b, bus_b.wr_ready, busy_b);
    end
    checks++;
    if ($countones(e_c) > 1 || bus_c.wr_ready !== !busy_c || (e_c != 0 && d_c !== prev_d_c)) begin
      errors++;
      $display("FAIL inv_c E=%h D=%h prevD=%h ready=%b busy=%b", e_c, d_c, prev_d_c, bus_c.wr_ready, busy_c);
    end
    prev_d_a = d_a;
    prev_d_b = d_b;
    prev_d_c = d_c;
  end

  task automatic tick;
    @(posedge CLK);
    #1;
  endtask

  task automatic test_reset;
    rst_a = 1'b1; rst_b = 1'b1; rst_c = 1'b1;
    #1;
    checks++;
    if (e_a !== 8'h00 || d_a !== 4'h0) begin
      errors++; $display("FAIL reset_ed E=%h D=%h want E=00 D=0", e_a, d_a);
    end
    checks++;
    if (bus_a.wr_ready !== 1'b1 || busy_a !== 1'b0) begin
      errors++; $display("FAIL reset_ready ready=%b busy=%b want 1 0", bus_a.wr_ready, busy_a);
    end
    checks++;
    if (done_a !== 1'b0 || err_a !== 1'b0) begin
      errors++; $display("FAIL reset_done done=%b err=%b want 0 0", done_a, err_a);
    end
    checks++;
    if (e_b !== 6'h00 || e_c !== 8'h00 || bus_b.wr_ready !== 1'b1 || bus_c.wr_ready !== 1'b1) begin
      errors++; $display("FAIL reset_bc Eb=%h Ec=%h rb=%b rc=%b want 0 0 1 1", e_b, e_c, bus_b.wr_ready, bus_c.wr_ready);
    end
    tick; tick;
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    tick;
  endtask

  task automatic test_single_write;
    bus_a.wr_addr = 3'd3; bus_a.wr_data = 4'hA; bus_a.wr_valid = 1'b1;
    tick;
    bus_a.wr_valid = 1'b0;
    checks++;
    if (d_a !== 4'hA || e_a !== 8'h00 || busy_a !== 1'b1 || bus_a.wr_ready !== 1'b0) begin
      errors++; $display("FAIL single_setup D=%h E=%h busy=%b ready=%b want A 00 1 0", d_a, e_a, busy_a, bus_a.wr_ready);
    end
    tick;
    checks++;
    if (e_a !== 8'h08 || d_a !== 4'hA) begin
      errors++; $display("FAIL single_open E=%h D=%h want 08 A", e_a, d_a);
    end
    tick;
    checks++;
    if (e_a !== 8'h00 || done_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++; $display("FAIL single_hold E=%h done=%b busy=%b want 00 0 1", e_a, done_a, busy_a);
    end
    tick;
    checks++;
    if (done_a !== 1'b1 || bus_a.wr_ready !== 1'b1 || err_a !== 1'b0 || busy_a !== 1'b0) begin
      errors++; $display("FAIL single_done done=%b ready=%b err=%b busy=%b want 1 1 0 0", done_a, bus_a.wr_ready, err_a, busy_a);
    end
    tick;
    checks++;
    if (done_a !== 1'b0 || d_a !== 4'hA) begin
      errors++; $display("FAIL single_after done=%b D=%h want 0 A", done_a, d_a);
    end
  endtask

  task automatic test_back_to_back;
    bus_a.wr_addr = 3'd0; bus_a.wr_data = 4'h5; bus_a.wr_valid = 1'b1;
    tick;
    bus_a.wr_addr = 3'd7; bus_a.wr_data = 4'hC;
    checks++;
    if (d_a !== 4'h5) begin
      errors++; $display("FAIL b2b_first_d D=%h want 5", d_a);
    end
    tick;
    checks++;
    if (e_a !== 8'h01) begin
      errors++; $display("FAIL b2b_first_e E=%h want 01", e_a);
    end
    tick; tick;
    checks++;
    if (done_a !== 1'b1 || bus_a.wr_ready !== 1'b1 || d_a !== 4'h5) begin
      errors++; $display("FAIL b2b_first_done done=%b ready=%b D=%h want 1 1 5", done_a, bus_a.wr_ready, d_a);
    end
    tick;
    bus_a.wr_valid = 1'b0;
    checks++;
    if (d_a !== 4'hC || done_a !== 1'b0 || busy_a !== 1'b1) begin
      errors++; $display("FAIL b2b_second_acc D=%h done=%b busy=%b want C 0 1", d_a, done_a, busy_a);
    end
    tick;
    checks++;
    if (e_a !== 8'h80) begin
      errors++; $display("FAIL b2b_second_e E=%h want 80", e_a);
    end
    tick; tick;
    checks++;
    if (done_a !== 1'b1 || e_a !== 8'h00) begin
      errors++; $display("FAIL b2b_second_done done=%b E=%h want 1 00", done_a, e_a);
    end
    tick;
  endtask

  task automatic test_valid_toggle;
    bus_a.wr_addr = 3'd2; bus_a.wr_data = 4'h6; bus_a.wr_valid = 1'b1;
    tick;
    bus_a.wr_addr = 3'd5; bus_a.wr_data = 4'hF;
    checks++;
    if (d_a !== 4'h6) begin
      errors++; $display("FAIL toggle_setup D=%h want 6", d_a);
    end
    tick;
    bus_a.wr_valid = 1'b0;
    checks++;
    if (e_a !== 8'h04 || d_a !== 4'h6) begin
      errors++; $display("FAIL toggle_open E=%h D=%h want 04 6", e_a, d_a);
    end
    tick;
    bus_a.wr_valid = 1'b1;
    checks++;
    if (e_a !== 8'h00 || d_a !== 4'h6) begin
      errors++; $display("FAIL toggle_hold E=%h D=%h want 00 6", e_a, d_a);
    end
    tick;
    bus_a.wr_valid = 1'b0;
    checks++;
    if (done_a !== 1'b1 || d_a !== 4'h6) begin
      errors++; $display("FAIL toggle_done done=%b D=%h want 1 6", done_a, d_a);
    end
    tick;
    checks++;
    if (d_a !== 4'h6 || busy_a !== 1'b0 || e_a !== 8'h00 || done_a !== 1'b0) begin
      errors++; $display("FAIL toggle_idle D=%h busy=%b E=%h done=%b want 6 0 00 0", d_a, busy_a, e_a, done_a);
    end
  endtask

  task automatic test_reset_open;
    bus_a.wr_addr = 3'd1; bus_a.wr_data = 4'h9; bus_a.wr_valid = 1'b1;
    tick;
    bus_a.wr_valid = 1'b0;
    tick;
    checks++;
    if (e_a !== 8'h02) begin
      errors++; $display("FAIL rstopen_pre E=%h want 02", e_a);
    end
    #2;
    rst_a = 1'b1;
    #1;
    checks++;
    if (e_a !== 8'h00 || d_a !== 4'h0 || bus_a.wr_ready !== 1'b1 || busy_a !== 1'b0) begin
      errors++; $display("FAIL rstopen_async E=%h D=%h ready=%b busy=%b want 00 0 1 0", e_a, d_a, bus_a.wr_ready, busy_a);
    end
    tick;
    rst_a = 1'b0;
    for (int k = 0; k < 5; k++) begin
      tick;
      checks++;
      if (done_a !== 1'b0 || busy_a !== 1'b0 || e_a !== 8'h00) begin
        errors++; $display("FAIL rstopen_after cyc=%0d done=%b busy=%b E=%h want 0 0 00", k, done_a, busy_a, e_a);
      end
    end
  endtask

  task automatic test_out_of_range;
    bus_b.wr_addr = 3'd6; bus_b.wr_data = 4'h3; bus_b.wr_valid = 1'b1;
    tick;
    bus_b.wr_valid = 1'b0;
    for (int j = 0; j < 3; j++) begin
      checks++;
      if (e_b !== 6'h00 || d_b !== 4'h3 || done_b !== 1'b0 || err_b !== 1'b0) begin
        errors++; $display("FAIL oor_seq cyc=%0d E=%h D=%h done=%b err=%b want 00 3 0 0", j, e_b, d_b, done_b, err_b);
      end
      tick;
    end
    checks++;
    if (done_b !== 1'b1 || err_b !== 1'b1 || e_b !== 6'h00) begin
      errors++; $display("FAIL oor_end done=%b err=%b E=%h want 1 1 00", done_b, err_b, e_b);
    end
    bus_b.wr_addr = 3'd5; bus_b.wr_data = 4'h1; bus_b.wr_valid = 1'b1;
    tick;
    bus_b.wr_valid = 1'b0;
    checks++;
    if (err_b !== 1'b0 || done_b !== 1'b0 || d_b !== 4'h1) begin
      errors++; $display("FAIL oor_clear err=%b done=%b D=%h want 0 0 1", err_b, done_b, d_b);
    end
    tick;
    checks++;
    if (e_b !== 6'h20) begin
      errors++; $display("FAIL inrange_e E=%h want 20", e_b);
    end
    tick; tick;
    checks++;
    if (done_b !== 1'b1 || err_b !== 1'b0) begin
      errors++; $display("FAIL inrange_done done=%b err=%b want 1 0", done_b, err_b);
    end
    tick;
  endtask

  task automatic test_long_phases;
    logic [7:0] exp_e;
    logic       exp_done;
    bus_c.wr_addr = 3'd1; bus_c.wr_data = 4'hB; bus_c.wr_valid = 1'b1;
    tick;
    bus_c.wr_valid = 1'b0;
    for (int j = 0; j <= 8; j++) begin
      exp_e    = (j >= 2 && j <= 4) ? 8'h02 : 8'h00;
      exp_done = (j == 7);
      checks++;
      if (e_c !== exp_e || done_c !== exp_done || d_c !== 4'hB) begin
        errors++; $display("FAIL long_seq cyc=%0d E=%h done=%b D=%h want %h %b B", j, e_c, done_c, d_c, exp_e, exp_done);
      end
      tick;
    end
  endtask

  initial begin
    rst_a = 1'b0; rst_b = 1'b0; rst_c = 1'b0;
    bus_a.wr_valid = 1'b0; bus_a.wr_addr = '0; bus_a.wr_data = '0;
    bus_b.wr_valid = 1'b0; bus_b.wr_addr = '0; bus_b.wr_data = '0;
    bus_c.wr_valid = 1'b0; bus_c.wr_addr = '0; bus_c.wr_data = '0;
    #1;
    test_reset;
    test_single_write;
    test_back_to_back;
    test_valid_toggle;
    test_reset_open;
    test_out_of_range;
    test_long_phases;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
